// File: rtl/processor_mem_arbiter.sv
// rtl/processor_mem_arbiter.sv - processor/host data-memory port arbiter
// Optional host starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module processor_mem_arbiter #(
    parameter int ADDR_SIZE         = 18,
    parameter int WORD_SIZE         = 18,
    parameter int HOST_STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_grant,
    output logic                 cpu_stall,
    output logic                 cpu_rvalid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [WORD_SIZE-1:0] host_wdata,
    output logic                 host_grant,
    output logic                 host_rvalid,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] rdata
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;

    if (HOST_STARVE_LIMIT < 1) begin : g_bad_limit
        $error("HOST_STARVE_LIMIT must be at least 1");
    end

    logic       force_host;
    logic [1:0] rd_owner;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(HOST_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOST_STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // Host takes the slot once it has been refused LIMIT cycles in a row.
    assign force_host = host_req && (starve_cnt == LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!host_req || host_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_host = 1'b0;
`endif

    assign cpu_grant  = !reset && cpu_req && !force_host;
    assign host_grant = !reset && host_req && (!cpu_req || force_host);
    assign cpu_stall  = !reset && cpu_req && !cpu_grant;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (host_grant) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_wdata = host_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_owner <= OWN_NONE;
        end else if (cpu_grant && !cpu_we) begin
            rd_owner <= OWN_CPU;
        end else if (host_grant && !host_we) begin
            rd_owner <= OWN_HOST;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    // Reset in the return cycle discards the pending read result.
    assign cpu_rvalid  = !reset && (rd_owner == OWN_CPU);
    assign host_rvalid = !reset && (rd_owner == OWN_HOST);
    assign rdata       = mem_rdata;

endmodule

// File: doc/processor_mem_arbiter.md
# processor_mem_arbiter

Shares the single synchronous data-memory port between the processor pipeline (load/store path feeding `memory_out`) and a host/debug requester (loader, monitor). Grants are combinational, so a granted access reaches the memory in the same cycle. Read data returns one cycle later, tagged for the owning requester. A stall output freezes the pipeline whenever its access is refused. An optional starvation guard guarantees the host a slot under continuous processor traffic.

## Interface
Parameters:
- ADDR_SIZE, 18, memory address width
- WORD_SIZE, 18, data word width
- HOST_STARVE_LIMIT, 4, maximum number of consecutive refused host cycles before a forced host slot; legal range ≥1

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  processor access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_SIZE  processor address
- cpu_wdata  in  WORD_SIZE  processor write data
- cpu_grant  out  1  processor access performed this cycle
- cpu_stall  out  1  cpu_req && !cpu_grant
- cpu_rvalid  out  1  mem_rdata is the processor's read result this cycle
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_SIZE/WORD_SIZE  same meaning for the host
- host_grant  out  1  host access performed this cycle
- host_rvalid  out  1  mem_rdata is the host's read result this cycle
- mem_addr  out  ADDR_SIZE  to RAM
- mem_we  out  1  to RAM
- mem_wdata  out  WORD_SIZE  to RAM
- mem_rdata  in  WORD_SIZE  from RAM, valid one cycle after the read address
- rdata  out  WORD_SIZE  equals mem_rdata; qualified by cpu_rvalid or host_rvalid

## Operation
- Base policy: fixed priority to the processor. cpu_grant = cpu_req. host_grant = host_req && !cpu_req.
- Starve counter `starve_cnt`:
  - width $clog2(HOST_STARVE_LIMIT+1)
  - increments each cycle host_req && !host_grant
  - cleared when host_grant is 1 or host_req is 0
  - never exceeds HOST_STARVE_LIMIT
- Forced slot: when starve_cnt == HOST_STARVE_LIMIT and host_req = 1, then host_grant = 1 and cpu_grant = 0. cpu_stall is 1 if cpu_req = 1.
- Port mux:
  - selected requester's addr, we and wdata drive mem_*
  - with no grant: mem_we = 0, mem_addr = 0, mem_wdata = 0
- Read tracking: registers `rd_owner` (none/cpu/host) latch the granted requester when its we = 0. The matching *_rvalid is 1 in the next cycle only. Writes never produce rvalid.
- Both grants are never 1 in the same cycle.
- Requesters may change addr/we/wdata only in a cycle after their grant.

## Timing
- Grant, stall and mem_* are combinational from the req inputs, the counter and reset. The path is zero-latency.
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1. Back-to-back reads stream one per cycle.
- Write: committed by the RAM at the end of the grant cycle.
- While reset = 1:
  - grants are 0, cpu_stall = 0, mem_we = 0 (combinational override)
  - at the clock edge, starve_cnt is cleared and rd_owner becomes none
- After reset: cpu_rvalid = 0, host_rvalid = 0, starve_cnt = 0.
- Reset asserted in the cycle after a read grant: that read's rvalid is dropped.
- Simultaneous requests with starve_cnt < LIMIT: the processor wins and starve_cnt increments.

## Configuration
- Macro `MEM_ARB_STARVE_GUARD_EN`.
- Defined: the starve counter and forced host slot are present as described.
- Undefined: no counter is built. The policy is strict processor priority. The host is granted only in cycles with cpu_req = 0. HOST_STARVE_LIMIT is ignored.

## Test plan
- Reset held 3 cycles with both reqs high: grants 0, mem_we 0, stall 0. First cycle after reset: rvalids 0.
- CPU read addr 5, RAM[5] = 18'h2A5A5, host idle: cpu_grant in cycle N. Cycle N+1: cpu_rvalid = 1, rdata = 18'h2A5A5, host_rvalid = 0.
- Host write addr 7 = 18'h00123 with cpu_req = 0: host_grant and mem_we in the same cycle. A later CPU read of addr 7 returns 18'h00123.
- Guard enabled, LIMIT = 4, both requesting continuously for 10 cycles: cpu_grant in cycles 0–3 and 5–8. host_grant in cycles 4 and 9. cpu_stall = 1 only in cycles 4 and 9.
- Guard disabled, both requesting for 20 cycles: host_grant never 1. Releasing cpu_req gives host_grant in the same cycle.
- CPU read granted in cycle N, reset = 1 in cycle N+1: cpu_rvalid = 0 in N+1 and N+2.
